// File: rtl/axi4s_burst_scheduler.sv
// Burst scheduler: drives the AXI4-Stream generator through N packets of L beats with idle gaps.
// Optional stall watchdog (o_timeout port) is built when AXI4S_SCHED_TIMEOUT_EN is defined.
module axi4s_burst_scheduler #(
  parameter int unsigned LEN_W          = 32,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned GAP_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             i_aclk,
  input  logic             i_rst,
  input  logic             i_cfg_go,
  input  logic             i_cfg_abort,
  input  logic [LEN_W-1:0] i_cfg_pkt_len,
  input  logic [CNT_W-1:0] i_cfg_pkt_cnt,
  input  logic [GAP_W-1:0] i_cfg_gap,
  output logic             o_gen_start,
  output logic [LEN_W-1:0] o_gen_trans_size,
  input  logic             i_tvalid,
  input  logic             i_tready,
  input  logic             i_tlast,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_pkts_sent,
  output logic             o_len_err,
  output logic             o_aborted
`ifdef AXI4S_SCHED_TIMEOUT_EN
  ,
  output logic             o_timeout
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StGap, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [LEN_W-1:0] r_len, w_len_d, r_beat, w_beat_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d, r_pkts, w_pkts_d;
  logic [GAP_W-1:0] r_gap, w_gap_d, r_gap_left, w_gap_left_d;
  logic             r_gen_start, r_busy, r_done;
  logic             r_len_err, w_len_err_d, r_aborted, w_aborted_d;
  logic             w_beat, w_last, w_pkt_final, w_stop, w_timeout_hit;

  assign w_beat      = i_tvalid & i_tready;
  assign w_last      = (r_beat == r_len - LEN_W'(1));
  assign w_pkt_final = (({1'b0, r_pkts} + (CNT_W + 1)'(1)) == {1'b0, r_cnt});
  assign w_stop      = i_cfg_abort | w_timeout_hit;

`ifdef AXI4S_SCHED_TIMEOUT_EN
  localparam int unsigned StallW = $clog2(TIMEOUT_CYCLES + 1);
  logic [StallW-1:0] r_stall, w_stall_d;
  logic              r_timeout;

  assign w_timeout_hit = (r_state == StRun) && !w_beat &&
                         (r_stall == StallW'(TIMEOUT_CYCLES - 1));
  assign w_stall_d     = ((r_state == StRun) && !w_beat) ? r_stall + StallW'(1) : '0;

  always_ff @(posedge i_aclk or posedge i_rst) begin
    if (i_rst) begin
      r_stall   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_stall   <= w_stall_d;
      r_timeout <= w_timeout_hit;
    end
  end

  assign o_timeout = r_timeout;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout_hit    = 1'b0;
`endif

  always_comb begin
    w_state_d    = r_state;
    w_len_d      = r_len;
    w_cnt_d      = r_cnt;
    w_gap_d      = r_gap;
    w_beat_d     = r_beat;
    w_pkts_d     = r_pkts;
    w_gap_left_d = r_gap_left;
    w_len_err_d  = r_len_err;
    w_aborted_d  = r_aborted;
    unique case (r_state)
      StIdle: begin
        if (i_cfg_go) begin
          w_len_d     = i_cfg_pkt_len;
          w_cnt_d     = i_cfg_pkt_cnt;
          w_gap_d     = i_cfg_gap;
          w_beat_d    = '0;
          w_pkts_d    = '0;
          w_len_err_d = 1'b0;
          w_aborted_d = 1'b0;
          w_state_d   = ((i_cfg_pkt_len == '0) || (i_cfg_pkt_cnt == '0)) ? StDone : StRun;
        end
      end
      StRun: begin
        // Abort beats a coincident final beat: nothing is counted.
        if (w_stop) begin
          w_state_d   = StIdle;
          w_aborted_d = 1'b1;
        end else if (w_beat) begin
          if (i_tlast != w_last) w_len_err_d = 1'b1;
          if (w_last) begin
            w_beat_d = '0;
            w_pkts_d = r_pkts + CNT_W'(1);
            if (w_pkt_final) begin
              w_state_d = StDone;
            end else if (r_gap != '0) begin
              w_state_d    = StGap;
              w_gap_left_d = r_gap;
            end
          end else begin
            w_beat_d = r_beat + LEN_W'(1);
          end
        end
      end
      StGap: begin
        if (w_stop) begin
          w_state_d   = StIdle;
          w_aborted_d = 1'b1;
        end else if (r_gap_left <= GAP_W'(1)) begin
          w_state_d = StRun;
        end else begin
          w_gap_left_d = r_gap_left - GAP_W'(1);
        end
      end
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_aclk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_len       <= '0;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_beat      <= '0;
      r_pkts      <= '0;
      r_gap_left  <= '0;
      r_len_err   <= 1'b0;
      r_aborted   <= 1'b0;
      r_gen_start <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_len       <= w_len_d;
      r_cnt       <= w_cnt_d;
      r_gap       <= w_gap_d;
      r_beat      <= w_beat_d;
      r_pkts      <= w_pkts_d;
      r_gap_left  <= w_gap_left_d;
      r_len_err   <= w_len_err_d;
      r_aborted   <= w_aborted_d;
      r_gen_start <= (w_state_d == StRun);
      r_busy      <= (w_state_d != StIdle);
      r_done      <= (w_state_d == StDone);
    end
  end

  assign o_gen_start      = r_gen_start;
  assign o_gen_trans_size = r_len;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_pkts_sent      = r_pkts;
  assign o_len_err        = r_len_err;
  assign o_aborted        = r_aborted;

endmodule

// File: tb/tb_axi4s_burst_scheduler.sv
// Randomised/directed bench for axi4s_burst_scheduler against a burst-level reference model.
module tb_axi4s_burst_scheduler;
  localparam int LEN_W = 32;
  localparam int CNT_W = 16;
  localparam int GAP_W = 16;
  localparam int TO    = 16;

  logic             clk = 1'b0;
  logic             i_rst, i_cfg_go, i_cfg_abort, i_tvalid, i_tready, i_tlast;
  logic [LEN_W-1:0] i_cfg_pkt_len;
  logic [CNT_W-1:0] i_cfg_pkt_cnt;
  logic [GAP_W-1:0] i_cfg_gap;
  logic             o_gen_start, o_busy, o_done, o_len_err, o_aborted;
  logic [LEN_W-1:0] o_gen_trans_size;
  logic [CNT_W-1:0] o_pkts_sent;
`ifdef AXI4S_SCHED_TIMEOUT_EN
  logic             o_timeout;
`endif

  always #5 clk = ~clk;

  axi4s_burst_scheduler #(
    .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_W(GAP_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_aclk(clk), .i_rst(i_rst), .i_cfg_go(i_cfg_go), .i_cfg_abort(i_cfg_abort),
    .i_cfg_pkt_len(i_cfg_pkt_len), .i_cfg_pkt_cnt(i_cfg_pkt_cnt), .i_cfg_gap(i_cfg_gap),
    .o_gen_start(o_gen_start), .o_gen_trans_size(o_gen_trans_size),
    .i_tvalid(i_tvalid), .i_tready(i_tready), .i_tlast(i_tlast),
    .o_busy(o_busy), .o_done(o_done), .o_pkts_sent(o_pkts_sent),
    .o_len_err(o_len_err), .o_aborted(o_aborted)
`ifdef AXI4S_SCHED_TIMEOUT_EN
    , .o_timeout(o_timeout)
`endif
  );

  int n_tests = 0, n_fail = 0;
  int n_hi, n_lo, n_dn, n_to;

  // Reference model: burst progress tracked as total beats, packets derived by division.
  int m_len, m_cnt, m_gap, m_beats, m_gap_left, m_pkts, m_stall;
  bit m_busy, m_gen, m_done, m_err, m_abt, m_to;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_len = 0; m_cnt = 0; m_gap = 0; m_beats = 0; m_gap_left = 0; m_pkts = 0; m_stall = 0;
    m_busy = 0; m_gen = 0; m_done = 0; m_err = 0; m_abt = 0; m_to = 0;
  endtask

  task automatic model_step();
    bit beat, nd, hit;
    int pos;
    beat = m_gen && i_tvalid && i_tready;
    nd = 0; hit = 0; m_to = 0;
`ifdef AXI4S_SCHED_TIMEOUT_EN
    hit = m_gen && !beat && (m_stall + 1 == TO);
    m_stall = (m_gen && !beat) ? m_stall + 1 : 0;
`endif
    if (!m_busy) begin
      if (i_cfg_go) begin
        m_len = int'(i_cfg_pkt_len); m_cnt = int'(i_cfg_pkt_cnt); m_gap = int'(i_cfg_gap);
        m_pkts = 0; m_beats = 0; m_err = 0; m_abt = 0; m_busy = 1;
        if (m_len == 0 || m_cnt == 0) begin m_gen = 0; nd = 1; end
        else m_gen = 1;
      end
    end else if (m_done) begin
      m_busy = 0;
    end else if (i_cfg_abort || hit) begin
      m_busy = 0; m_gen = 0; m_abt = 1; m_to = hit;
    end else if (m_gen) begin
      if (beat) begin
        pos = m_beats % m_len;
        if (i_tlast != (pos == m_len - 1)) m_err = 1;
        m_beats++;
        if (m_beats % m_len == 0) begin
          m_pkts = m_beats / m_len;
          if (m_pkts == m_cnt) begin m_gen = 0; nd = 1; end
          else if (m_gap > 0) begin m_gen = 0; m_gap_left = m_gap; end
        end
      end
    end else begin
      m_gap_left--;
      if (m_gap_left == 0) m_gen = 1;
    end
    m_done = nd;
  endtask

  task automatic check_outputs();
    chk("gen_start", o_gen_start, m_gen);
    chk("busy", o_busy, m_busy);
    chk("done", o_done, m_done);
    chk("pkts_sent", o_pkts_sent, m_pkts);
    chk("len_err", o_len_err, m_err);
    chk("aborted", o_aborted, m_abt);
    chk("trans_size", o_gen_trans_size, m_len);
`ifdef AXI4S_SCHED_TIMEOUT_EN
    chk("timeout", o_timeout, m_to);
`endif
  endtask

  // Drive one cycle's inputs from a negedge, advance the model, check at the next negedge.
  task automatic cycle(input bit go, input bit ab, input bit tv, input bit tr, input bit tl);
    i_cfg_go = go; i_cfg_abort = ab; i_tvalid = tv; i_tready = tr; i_tlast = tl;
    model_step();
    @(negedge clk);
    check_outputs();
    if (o_busy === 1'b1 && o_gen_start === 1'b1) n_hi++;
    if (o_busy === 1'b1 && o_gen_start === 1'b0) n_lo++;
    if (o_done === 1'b1) n_dn++;
`ifdef AXI4S_SCHED_TIMEOUT_EN
    if (o_timeout === 1'b1) n_to++;
`endif
  endtask

  // bad_pos: -1 correct TLAST, -2 random TLAST errors, >=0 TLAST only at that beat position.
  task automatic run_burst(input int len, input int cnt, input int gap, input int pct,
                           input int bad_pos, input int abort_at, input bit noisy);
    n_hi = 0; n_lo = 0; n_dn = 0; n_to = 0;
    i_cfg_pkt_len = LEN_W'(len); i_cfg_pkt_cnt = CNT_W'(cnt); i_cfg_gap = GAP_W'(gap);
    cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 3000 && m_busy; k++) begin
      bit tv, tr, tl, ab, go;
      int pos;
      tv = ($urandom_range(99) < pct);
      tr = ($urandom_range(99) < pct);
      pos = (m_len != 0) ? m_beats % m_len : 0;
      if (bad_pos == -1) tl = (pos == m_len - 1);
      else if (bad_pos == -2) tl = (pos == m_len - 1) ^ ($urandom_range(9) == 0);
      else tl = (pos == bad_pos);
      ab = (abort_at >= 0) && (m_beats == abort_at);
      go = 0;
      if (noisy && $urandom_range(5) == 0) begin
        go = 1;
        i_cfg_pkt_len = LEN_W'($urandom_range(9));
        i_cfg_pkt_cnt = CNT_W'($urandom_range(9));
        i_cfg_gap     = GAP_W'($urandom_range(9));
      end
      cycle(go, ab, tv, tr, tl);
    end
    n_tests++;
    assert (!m_busy) else begin
      n_fail++;
      $error("FAIL burst_bound: burst still busy after 3000 cycles, required idle");
    end
    i_cfg_pkt_len = LEN_W'(len); i_cfg_pkt_cnt = CNT_W'(cnt); i_cfg_gap = GAP_W'(gap);
    cycle(0, 0, 0, 0, 0);
  endtask

  initial begin
    i_rst = 1'b1; i_cfg_go = 0; i_cfg_abort = 0; i_tvalid = 0; i_tready = 0; i_tlast = 0;
    i_cfg_pkt_len = '0; i_cfg_pkt_cnt = '0; i_cfg_gap = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    i_rst = 1'b0;
    cycle(0, 0, 0, 0, 0);

    // Back-to-back packets, no gap.
    run_burst(4, 3, 0, 100, -1, -1, 0);
    chk("tp1_gen_hi", n_hi, 12);
    chk("tp1_busy_lo", n_lo, 1);
    chk("tp1_done", n_dn, 1);
    chk("tp1_pkts", o_pkts_sent, 3);
    chk("tp1_err", o_len_err, 0);

    // Gap of 5 cycles between two packets.
    run_burst(2, 2, 5, 100, -1, -1, 0);
    chk("tp2_gen_hi", n_hi, 4);
    chk("tp2_busy_lo", n_lo, 6);
    chk("tp2_done", n_dn, 1);
    chk("tp2_pkts", o_pkts_sent, 2);

    // Early TLAST: error flagged but packet length follows the count.
    run_burst(4, 1, 0, 100, 1, -1, 0);
    chk("tp3_err", o_len_err, 1);
    chk("tp3_gen_hi", n_hi, 4);
    chk("tp3_done", n_dn, 1);
    chk("tp3_pkts", o_pkts_sent, 1);

    // Abort after 11 beats, then restart clears flags.
    run_burst(8, 4, 0, 100, -1, 11, 0);
    chk("tp4_aborted", o_aborted, 1);
    chk("tp4_pkts", o_pkts_sent, 1);
    chk("tp4_done", n_dn, 0);
    chk("tp4_busy", o_busy, 0);
    run_burst(3, 2, 1, 100, -1, -1, 0);
    chk("tp4_restart_aborted", o_aborted, 0);
    chk("tp4_restart_pkts", o_pkts_sent, 2);

    // Empty bursts.
    run_burst(5, 0, 2, 100, -1, -1, 0);
    chk("tp5_gen_hi", n_hi, 0);
    chk("tp5_done", n_dn, 1);
    chk("tp5_pkts", o_pkts_sent, 0);
    run_burst(0, 3, 0, 100, -1, -1, 0);
    chk("tp5_len0_done", n_dn, 1);
    chk("tp5_len0_gen_hi", n_hi, 0);

    // cfg_go and cfg changes while busy are ignored.
    run_burst(3, 3, 1, 100, -1, -1, 1);
    chk("busy_go_size", o_gen_trans_size, 3);
    chk("busy_go_pkts", o_pkts_sent, 3);
    chk("busy_go_done", n_dn, 1);

    // Asynchronous reset in the middle of RUN.
    i_cfg_pkt_len = 8; i_cfg_pkt_cnt = 4; i_cfg_gap = 2;
    cycle(1, 0, 0, 0, 0);
    repeat (6) cycle(0, 0, 1, 1, 0);
    #2 i_rst = 1'b1;
    #1;
    chk("rst_gen_start", o_gen_start, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_pkts", o_pkts_sent, 0);
    chk("rst_size", o_gen_trans_size, 0);
    chk("rst_done", o_done, 0);
    model_reset();
    @(negedge clk);
    i_rst = 1'b0;
    cycle(0, 0, 1, 1, 0);

`ifdef AXI4S_SCHED_TIMEOUT_EN
    // Stalled stream trips the watchdog.
    run_burst(4, 2, 0, 0, -1, -1, 0);
    chk("to_gen_hi", n_hi, TO);
    chk("to_pulse", n_to, 1);
    chk("to_aborted", o_aborted, 1);
    chk("to_busy", o_busy, 0);
`endif

    // Random bursts with random handshakes, TLAST errors, aborts and ignored re-starts.
    repeat (25) begin
      int ab;
      ab = ($urandom_range(3) == 0) ? int'($urandom_range(12)) : -1;
      run_burst(int'($urandom_range(1, 6)), int'($urandom_range(4)), int'($urandom_range(3)),
                int'($urandom_range(40, 100)), -2, ab, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
